rst_seq_ctrl: RTL

Parametrised reset sequencer that replaces a single-output reset synchroniser. It synchronises release of an asynchronous active-low reset into one clock domain and drives NUM_CH active-low reset outputs. The outputs are released one at a time in ascending channel order, after a guaranteed minimum hold. It also accepts a synchronous software reset request, so the UART system can re-sequence its sub-blocks without an external reset.

---
 rtl/rst_pkg.sv | 18 +
 rtl/rst_sync_chain.sv | 24 ++
 rtl/rst_seq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_pkg;

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} rst_state_e;

  // Counter width: wide enough to hold max(MIN_ASSERT, STEP_CYCLES).
  function automatic int unsigned cnt_width(input int unsigned min_assert,
                                            input int unsigned step_cycles);
    int unsigned m;
    m = (min_assert > step_cycles) ? min_assert : step_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset-release synchroniser: async assert, deassert after NUM_STAGES edges.
module rst_sync_chain #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic srst_n
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign srst_n = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronised release of NUM_CH active-low resets in
// ascending order after a minimum hold, with a software re-sequence request.
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MIN_ASSERT  = 8,
  parameter int unsigned STEP_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              SW_RST_FLAG
);

  localparam int unsigned CNT_W = cnt_width(MIN_ASSERT, STEP_CYCLES);
  localparam int unsigned CH_W  = ch_width(NUM_CH);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  logic srst_n;

  rst_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] sync_rst_q, sync_rst_d;
  logic              rst_done_q, rst_done_d;
  logic              sw_flag_q, sw_flag_d;

  rst_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .srst_n (srst_n)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    sync_rst_d = sync_rst_q;
    rst_done_d = rst_done_q;
    sw_flag_d  = sw_flag_q;

    unique case (state_q)
      SYNC: begin
        if (srst_n) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d    = RELEASE;
          sync_rst_d = NUM_CH'(1);
          ch_d       = '0;
          cnt_d      = '0;
          // Single-channel build finishes on the first release.
          if (CH_LAST == '0) begin
            state_d    = DONE;
            rst_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          ch_d       = ch_q + CH_W'(1);
          sync_rst_d = sync_rst_q | (NUM_CH'(1) << ch_d);
          cnt_d      = '0;
          if (ch_d == CH_LAST) begin
            state_d    = DONE;
            rst_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
      end
    endcase

    // Software request overrides any progress once the domain is out of reset.
    if (SW_RST_REQ && (state_q != SYNC)) begin
      state_d    = HOLD;
      cnt_d      = '0;
      ch_d       = '0;
      sync_rst_d = '0;
      rst_done_d = 1'b0;
      sw_flag_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= SYNC;
      cnt_q      <= '0;
      ch_q       <= '0;
      sync_rst_q <= '0;
      rst_done_q <= 1'b0;
      sw_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      sync_rst_q <= sync_rst_d;
      rst_done_q <= rst_done_d;
      sw_flag_q  <= sw_flag_d;
    end
  end

  assign SYNC_RST    = sync_rst_q;
  assign RST_DONE    = rst_done_q;
  assign SW_RST_FLAG = sw_flag_q;

endmodule
